// File: rtl/serial_operand_loader_pkg.sv
// Shared types for the serial operand loader: FSM state
// encoding and bit-counter width helper.
package serial_operand_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_operand_loader_piso_reg.sv
// piso_reg: W-bit parallel-load, right-shift register (zero fill).
// Ports: clk, rst (sync), load, shift_en, d[W], sout = bit 0.
module piso_reg
  import serial_operand_loader_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         sout
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = d;
    else if (shift_en)
      sr_d = {1'b0, sr_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign sout = sr_q[0];

endmodule

// File: rtl/serial_operand_loader.sv
// Parallel-to-serial operand front end for the bit-serial adder.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b, a, b, start, busy.
module serial_operand_loader
  import serial_operand_loader_pkg::*;
#(
  parameter int w = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [w-1:0] in_a,
  input  logic [w-1:0] in_b,
  output logic         a,
  output logic         b,
  output logic         start,
  output logic         busy
);

  localparam int CW = cnt_width(w);
  localparam logic [CW-1:0] LAST = CW'(w - 1);

  state_e        state_q, state_d;
  logic [w-1:0]  pend_a_q, pend_a_d;
  logic [w-1:0]  pend_b_q, pend_b_d;
  logic          pend_valid_q, pend_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          load, shift_en, xfer;

  assign in_ready = !pend_valid_q && !rst;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    busy_d       = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) load = 1'b1;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy_d   = 1'b1;
        if (cnt_q == LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        if (pend_valid_q) load = 1'b1;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
      start_d      = 1'b1;
      busy_d       = 1'b1;
    end
    // in_ready is low whenever a load can happen, so no conflict
    if (xfer) begin
      pend_a_d     = in_a;
      pend_b_d     = in_b;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  // Zero fill means the shift registers are empty once a frame
  // has shifted out, so their LSB is already 0 in FLUSH/IDLE.
  piso_reg #(.W(w)) u_sr_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .d        (pend_a_q),
    .sout     (a)
  );

  piso_reg #(.W(w)) u_sr_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .d        (pend_b_q),
    .sout     (b)
  );

  assign start = start_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed bench for serial_operand_loader (w = 6 and w = 8).
// Ports exercised: handshake, serial outputs, start, busy, reset.
module tb_serial_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv6, ir6, a6, b6, s6, bz6;
  logic [5:0] ia6, ib6;
  logic       iv8, ir8, a8, b8, s8, bz8;
  logic [7:0] ia8, ib8;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start;
  logic [7:0] last_sum;
  logic       last_cout;

  always #5 clk = ~clk;

  serial_operand_loader #(.w(6)) u6 (
    .clk(clk), .rst(rst),
    .in_valid(iv6), .in_ready(ir6),
    .in_a(ia6), .in_b(ib6),
    .a(a6), .b(b6), .start(s6), .busy(bz6)
  );

  serial_operand_loader #(.w(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .in_a(ia8), .in_b(ib8),
    .a(a8), .b(b8), .start(s8), .busy(bz8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic o_a(input int sel);
    return sel != 0 ? a8 : a6;
  endfunction
  function automatic logic o_b(input int sel);
    return sel != 0 ? b8 : b6;
  endfunction
  function automatic logic o_s(input int sel);
    return sel != 0 ? s8 : s6;
  endfunction
  function automatic logic o_bz(input int sel);
    return sel != 0 ? bz8 : bz6;
  endfunction
  function automatic logic o_ir(input int sel);
    return sel != 0 ? ir8 : ir6;
  endfunction

  task automatic drive(input int sel, input logic v,
                       input logic [7:0] xa,
                       input logic [7:0] xb);
    if (sel != 0) begin
      iv8 = v; ia8 = xa; ib8 = xb;
    end else begin
      iv6 = v; ia6 = xa[5:0]; ib6 = xb[5:0];
    end
  endtask

  // Waits (bounded) for start, checks every bit and the flush
  // cycle, and runs a bit-serial adder over the observed bits.
  // Optionally offers the next pair during bit 0.
  task automatic run_frame(input string tag, input int sel,
                           input int wn,
                           input logic [7:0] ea,
                           input logic [7:0] eb,
                           input bit offer,
                           input logic [7:0] oa,
                           input logic [7:0] ob);
    int waited;
    logic c, s, xa, xb;
    logic [7:0] sum;
    waited = 0;
    while (o_s(sel) !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    chk({tag, "_start_seen"}, 32'(o_s(sel)), 32'd1);
    last_start = cyc;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < wn; i++) begin
      if (i > 0) step();
      if (i == 1 && offer) begin
        drive(sel, 1'b0, 8'h00, 8'h00);
        chk({tag, "_ready_full"}, 32'(o_ir(sel)), 32'd0);
      end
      chk({tag, "_a"}, 32'(o_a(sel)), 32'(ea[i]));
      chk({tag, "_b"}, 32'(o_b(sel)), 32'(eb[i]));
      chk({tag, "_start"}, 32'(o_s(sel)), 32'(i == 0));
      chk({tag, "_busy"}, 32'(o_bz(sel)), 32'd1);
      if (i == 0 && offer) begin
        chk({tag, "_ready_open"}, 32'(o_ir(sel)), 32'd1);
        drive(sel, 1'b1, oa, ob);
      end
      xa = o_a(sel);
      xb = o_b(sel);
      s  = xa ^ xb ^ c;
      c  = (xa & xb) | (xa & c) | (xb & c);
      sum[i] = s;
    end
    step();
    chk({tag, "_flush_a"}, 32'(o_a(sel)), 32'd0);
    chk({tag, "_flush_b"}, 32'(o_b(sel)), 32'd0);
    chk({tag, "_flush_start"}, 32'(o_s(sel)), 32'd0);
    chk({tag, "_flush_busy"}, 32'(o_bz(sel)), 32'd1);
    last_sum  = sum;
    last_cout = c;
  endtask

  initial begin
    int s1, idx, nfr, cap_i, starts, busies;
    bit saw_block, cap_on, rdy, vld;
    logic [5:0] pa [3];
    logic [5:0] pb [3];
    logic [5:0] fa [4];
    logic [5:0] fb [4];
    logic [5:0] ca, cb;

    // Reset
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    step();
    step();
    chk("rst_a", 32'(a6), 32'd0);
    chk("rst_b", 32'(b6), 32'd0);
    chk("rst_start", 32'(s6), 32'd0);
    chk("rst_busy", 32'(bz6), 32'd0);
    chk("rst_ready6", 32'(ir6), 32'd0);
    chk("rst_ready8", 32'(ir8), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(ir6), 32'd1);

    // Single op: 5 + 3
    drive(0, 1'b1, 8'd5, 8'd3);
    step();
    drive(0, 1'b0, 8'h2A, 8'h15);
    chk("t1_ready_full", 32'(ir6), 32'd0);
    chk("t1_no_start_yet", 32'(s6), 32'd0);
    run_frame("t1", 0, 6, 8'd5, 8'd3, 1'b0, 8'd0, 8'd0);
    chk("t1_sum", 32'(last_sum), 32'd8);
    chk("t1_cout", 32'(last_cout), 32'd0);
    step();
    chk("t1_idle_busy", 32'(bz6), 32'd0);
    chk("t1_idle_ready", 32'(ir6), 32'd1);

    // Two pairs back to back: (63,1) then (10,20)
    drive(0, 1'b1, 8'd63, 8'd1);
    step();
    drive(0, 1'b0, 8'd0, 8'd0);
    run_frame("t2a", 0, 6, 8'd63, 8'd1, 1'b1, 8'd10, 8'd20);
    s1 = last_start;
    chk("t2a_sum", 32'(last_sum), 32'd0);
    chk("t2a_cout", 32'(last_cout), 32'd1);
    run_frame("t2b", 0, 6, 8'd10, 8'd20, 1'b0, 8'd0, 8'd0);
    chk("t2_spacing", 32'(last_start - s1), 32'd7);
    chk("t2b_sum", 32'(last_sum), 32'd30);
    chk("t2b_cout", 32'(last_cout), 32'd0);
    step();
    chk("t2_idle_busy", 32'(bz6), 32'd0);

    // Backpressure: three pairs, in_valid held while queued
    pa[0] = 6'd7;  pb[0] = 6'd9;
    pa[1] = 6'd33; pb[1] = 6'd12;
    pa[2] = 6'd50; pb[2] = 6'd61;
    idx = 0; nfr = 0; cap_i = 0;
    saw_block = 1'b0; cap_on = 1'b0;
    ca = '0; cb = '0;
    for (int k = 0; k < 4; k++) begin
      fa[k] = '0; fb[k] = '0;
    end
    for (int k = 0; k < 40; k++) begin
      if (k < 20 && idx < 3)
        drive(0, 1'b1, 8'(pa[idx]), 8'(pb[idx]));
      else
        drive(0, 1'b0, 8'd0, 8'd0);
      #1;
      rdy = ir6;
      vld = iv6;
      if (vld && !rdy) saw_block = 1'b1;
      step();
      if (vld && rdy) idx++;
      if (s6) begin
        cap_on = 1'b1;
        cap_i  = 0;
      end
      if (cap_on) begin
        ca[cap_i] = a6;
        cb[cap_i] = b6;
        cap_i++;
        if (cap_i == 6) begin
          if (nfr < 4) begin
            fa[nfr] = ca;
            fb[nfr] = cb;
          end
          nfr++;
          cap_on = 1'b0;
        end
      end
    end
    drive(0, 1'b0, 8'd0, 8'd0);
    chk("t3_accepted", 32'(idx), 32'd3);
    chk("t3_blocked", 32'(saw_block), 32'd1);
    chk("t3_frames", 32'(nfr), 32'd3);
    chk("t3_f0_a", 32'(fa[0]), 32'd7);
    chk("t3_f0_b", 32'(fb[0]), 32'd9);
    chk("t3_f1_a", 32'(fa[1]), 32'd33);
    chk("t3_f1_b", 32'(fb[1]), 32'd12);
    chk("t3_f2_a", 32'(fa[2]), 32'd50);
    chk("t3_f2_b", 32'(fb[2]), 32'd61);
    chk("t3_idle_busy", 32'(bz6), 32'd0);

    // Reset mid-frame at bit 3, with a pair pending
    drive(0, 1'b1, 8'd42, 8'd21);
    step();
    drive(0, 1'b0, 8'd0, 8'd0);
    step();
    chk("t4_start", 32'(s6), 32'd1);
    drive(0, 1'b1, 8'd11, 8'd22);
    step();
    drive(0, 1'b0, 8'd0, 8'd0);
    chk("t4_pend_full", 32'(ir6), 32'd0);
    step();
    step();
    chk("t4_bit3_a", 32'(a6), 32'd1);
    chk("t4_bit3_b", 32'(b6), 32'd0);
    rst = 1'b1;
    step();
    chk("t4_rst_a", 32'(a6), 32'd0);
    chk("t4_rst_b", 32'(b6), 32'd0);
    chk("t4_rst_start", 32'(s6), 32'd0);
    chk("t4_rst_busy", 32'(bz6), 32'd0);
    chk("t4_rst_ready", 32'(ir6), 32'd0);
    rst = 1'b0;
    step();
    chk("t4_rel_ready", 32'(ir6), 32'd1);
    starts = 0;
    busies = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (s6) starts++;
      if (bz6) busies++;
    end
    chk("t4_no_stale_start", 32'(starts), 32'd0);
    chk("t4_no_stale_busy", 32'(busies), 32'd0);

    // w = 8: 0xFF + 0x01, then 0x80 + 0x7F back to back
    drive(1, 1'b1, 8'hFF, 8'h01);
    step();
    drive(1, 1'b0, 8'h00, 8'h00);
    run_frame("t5a", 1, 8, 8'hFF, 8'h01, 1'b1, 8'h80, 8'h7F);
    s1 = last_start;
    chk("t5a_sum", 32'(last_sum), 32'h00);
    chk("t5a_cout", 32'(last_cout), 32'd1);
    run_frame("t5b", 1, 8, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00);
    chk("t5_spacing", 32'(last_start - s1), 32'd9);
    chk("t5b_sum", 32'(last_sum), 32'hFF);
    chk("t5b_cout", 32'(last_cout), 32'd0);
    step();
    chk("t5_idle_busy", 32'(bz8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
